// File: rtl/rv32_mod_pc_ras.sv
// Fetch PC register with trap/redirect/sequential selection and a circular return-address stack.
// Latency: new PC appears on pc_current one cycle after the accepting edge; stall freezes PC and RAS.
module rv32_mod_pc_ras #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = XLEN'(32'h1000_0000),
  parameter int unsigned       RAS_DEPTH    = 4,
  parameter int unsigned       C_EXT        = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            is_compressed,
  output logic [XLEN-1:0] pc_current,
  output logic [XLEN-1:0] pc_next,
  input  logic            trap_enable,
  input  logic [XLEN-1:0] trap_target,
  input  logic            redirect_enable,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid,
  output logic            target_misaligned
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0]   COUNT_FULL = CW'(RAS_DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = (C_EXT != 0) ? XLEN'(1) : XLEN'(3);

  logic [XLEN-1:0] pc_step;
  logic [XLEN-1:0] pc_load;
  logic            misaligned_load;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr;
  logic [PW-1:0]   ras_ptr_nxt;
  logic [CW-1:0]   ras_count;
  logic [CW-1:0]   ras_count_nxt;
  logic            ras_we;
  logic [PW-1:0]   ras_waddr;
  logic            push_ok;
  logic            pop_ok;

  // Compressed step only exists when the C extension is built in.
  assign pc_step = ((C_EXT != 0) && is_compressed) ? XLEN'(2) : XLEN'(4);
  assign pc_next = pc_current + pc_step;

  always_comb begin
    pc_load         = pc_next;
    misaligned_load = 1'b0;
    if (trap_enable) begin
      pc_load         = trap_target & ~ALIGN_MASK;
      misaligned_load = |(trap_target & ALIGN_MASK);
    end else if (redirect_enable) begin
      pc_load         = redirect_target & ~ALIGN_MASK;
      misaligned_load = |(redirect_target & ALIGN_MASK);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_current        <= RESET_VECTOR;
      target_misaligned <= 1'b0;
    end else if (stall) begin
      target_misaligned <= 1'b0;
    end else begin
      pc_current        <= pc_load;
      target_misaligned <= misaligned_load;
    end
  end

  assign push_ok = ras_push && !stall && !reset;
  assign pop_ok  = ras_pop  && !stall && !reset;

  // Simultaneous push+pop replaces the top in place; on an empty stack it degrades to a push.
  always_comb begin
    ras_we        = 1'b0;
    ras_waddr     = ras_ptr;
    ras_ptr_nxt   = ras_ptr;
    ras_count_nxt = ras_count;
    if (push_ok && (!pop_ok || ras_count == '0)) begin
      ras_we      = 1'b1;
      ras_waddr   = ras_ptr + PW'(1);
      ras_ptr_nxt = ras_ptr + PW'(1);
      if (ras_count != COUNT_FULL) begin
        ras_count_nxt = ras_count + CW'(1);
      end
    end else if (push_ok && pop_ok) begin
      ras_we    = 1'b1;
      ras_waddr = ras_ptr;
    end else if (pop_ok && ras_count != '0) begin
      ras_ptr_nxt   = ras_ptr - PW'(1);
      ras_count_nxt = ras_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr   <= '0;
      ras_count <= '0;
    end else begin
      ras_ptr   <= ras_ptr_nxt;
      ras_count <= ras_count_nxt;
    end
  end

  // Entry storage carries no reset; stale contents are masked by ras_valid.
  always_ff @(posedge clk) begin
    if (ras_we) begin
      ras_mem[ras_waddr] <= pc_next;
    end
  end

  assign ras_top   = ras_mem[ras_ptr];
  assign ras_valid = (ras_count != '0);

endmodule

// File: tb/tb_rv32_mod_pc_ras.sv
// Vector-table bench for rv32_mod_pc_ras; a second C_EXT=0 instance shares the stimulus.
module tb_rv32_mod_pc_ras;

  localparam logic [31:0] RV = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset, stall, is_compressed;
  logic        trap_enable, redirect_enable, ras_push, ras_pop;
  logic [31:0] trap_target, redirect_target;
  logic [31:0] pc_current, pc_next, ras_top;
  logic        ras_valid, target_misaligned;
  logic [31:0] pc_current0, pc_next0, ras_top0;
  logic        ras_valid0, target_misaligned0;

  always #5 clk = ~clk;

  rv32_mod_pc_ras #(.XLEN(32), .RESET_VECTOR(RV), .RAS_DEPTH(4), .C_EXT(1)) dut (
    .clk(clk), .reset(reset), .stall(stall), .is_compressed(is_compressed),
    .pc_current(pc_current), .pc_next(pc_next),
    .trap_enable(trap_enable), .trap_target(trap_target),
    .redirect_enable(redirect_enable), .redirect_target(redirect_target),
    .ras_push(ras_push), .ras_pop(ras_pop), .ras_top(ras_top),
    .ras_valid(ras_valid), .target_misaligned(target_misaligned)
  );

  rv32_mod_pc_ras #(.XLEN(32), .RESET_VECTOR(RV), .RAS_DEPTH(4), .C_EXT(0)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .is_compressed(is_compressed),
    .pc_current(pc_current0), .pc_next(pc_next0),
    .trap_enable(trap_enable), .trap_target(trap_target),
    .redirect_enable(redirect_enable), .redirect_target(redirect_target),
    .ras_push(ras_push), .ras_pop(ras_pop), .ras_top(ras_top0),
    .ras_valid(ras_valid0), .target_misaligned(target_misaligned0)
  );

  typedef struct {
    logic        rst, stl, cmp, trp;
    logic [31:0] tt;
    logic        rd;
    logic [31:0] rt;
    logic        psh, pop;
    logic        chk_next;
    logic [31:0] e_next;
    logic [31:0] e_pc;
    logic        e_vld;
    logic        chk_top;
    logic [31:0] e_top;
    logic        e_mis;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] e_pc;
    logic        e_vld;
    logic        chk_top;
    logic [31:0] e_top;
    logic        e_mis;
    logic [31:0] e_pc0;
    logic        e_mis0;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m0_pc;
  logic        m0_mis;

  function automatic vec_t mk(logic rst, logic stl, logic cmp, logic trp, logic [31:0] tt,
                              logic rd, logic [31:0] rt, logic psh, logic pop,
                              logic [31:0] e_next, logic [31:0] e_pc, logic e_vld,
                              logic chk_top, logic [31:0] e_top, logic e_mis);
    vec_t v;
    v.rst = rst; v.stl = stl; v.cmp = cmp; v.trp = trp; v.tt = tt;
    v.rd = rd; v.rt = rt; v.psh = psh; v.pop = pop;
    v.chk_next = 1'b1; v.e_next = e_next; v.e_pc = e_pc; v.e_vld = e_vld;
    v.chk_top = chk_top; v.e_top = e_top; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    reset = v.rst; stall = v.stl; is_compressed = v.cmp;
    trap_enable = v.trp; trap_target = v.tt;
    redirect_enable = v.rd; redirect_target = v.rt;
    ras_push = v.psh; ras_pop = v.pop;
    #1;
    if (v.chk_next) begin
      chk($sformatf("v%0d pc_next", idx), pc_next, v.e_next);
      chk($sformatf("v%0d pc_next c0", idx), pc_next0, m0_pc + 32'd4);
    end
    // Independent reference for the 4-byte-aligned instance.
    if (v.rst) begin
      m0_pc = RV; m0_mis = 1'b0;
    end else if (v.stl) begin
      m0_mis = 1'b0;
    end else if (v.trp) begin
      m0_pc = {v.tt[31:2], 2'b00}; m0_mis = |v.tt[1:0];
    end else if (v.rd) begin
      m0_pc = {v.rt[31:2], 2'b00}; m0_mis = |v.rt[1:0];
    end else begin
      m0_pc = m0_pc + 32'd4; m0_mis = 1'b0;
    end
    e.idx = idx; e.e_pc = v.e_pc; e.e_vld = v.e_vld; e.chk_top = v.chk_top;
    e.e_top = v.e_top; e.e_mis = v.e_mis; e.e_pc0 = m0_pc; e.e_mis0 = m0_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d pc_current", e.idx), pc_current, e.e_pc);
    chk($sformatf("v%0d ras_valid", e.idx), {31'b0, ras_valid}, {31'b0, e.e_vld});
    chk($sformatf("v%0d misaligned", e.idx), {31'b0, target_misaligned}, {31'b0, e.e_mis});
    if (e.chk_top) chk($sformatf("v%0d ras_top", e.idx), ras_top, e.e_top);
    chk($sformatf("v%0d pc_current c0", e.idx), pc_current0, e.e_pc0);
    chk($sformatf("v%0d misaligned c0", e.idx), {31'b0, target_misaligned0}, {31'b0, e.e_mis0});
  endtask

  initial begin
    vec_t h;
    m0_pc = 'x;
    m0_mis = 1'b0;

    // Reset while stalled, before the PC is known.
    h = mk(1,1,0,0,0, 0,0, 0,0, 0, RV, 0, 0,0, 0);
    h.chk_next = 1'b0;
    apply(h, 100);
    apply(h, 101);

    //            rst stl cmp trp tt            rd rt            psh pop e_next        e_pc          vld ct e_top         mis
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         0,0, 32'h1000_0004,32'h1000_0004,0,0,32'h0,        0));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         0,0, 32'h1000_0008,32'h1000_0008,0,0,32'h0,        0));
    tbl.push_back(mk(0,0,1,0,32'h0,        0,32'h0,         0,0, 32'h1000_000A,32'h1000_000A,0,0,32'h0,        0));
    tbl.push_back(mk(0,1,0,0,32'h0,        0,32'h0,         1,0, 32'h1000_000E,32'h1000_000A,0,0,32'h0,        0));
    tbl.push_back(mk(0,1,0,0,32'h0,        0,32'h0,         0,0, 32'h1000_000E,32'h1000_000A,0,0,32'h0,        0));
    tbl.push_back(mk(0,1,0,0,32'h0,        0,32'h0,         0,0, 32'h1000_000E,32'h1000_000A,0,0,32'h0,        0));
    tbl.push_back(mk(0,0,0,0,32'h0,        1,32'hFFFF_FFFC, 0,0, 32'h1000_000E,32'hFFFF_FFFC,0,0,32'h0,        0));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         0,0, 32'h0000_0000,32'h0000_0000,0,0,32'h0,        0));
    tbl.push_back(mk(0,0,0,1,32'h0000_0100,1,32'h2000_0000, 0,0, 32'h0000_0004,32'h0000_0100,0,0,32'h0,        0));
    tbl.push_back(mk(0,0,0,0,32'h0,        1,32'h2000_0003, 0,0, 32'h0000_0104,32'h2000_0002,0,0,32'h0,        1));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         0,0, 32'h2000_0006,32'h2000_0006,0,0,32'h0,        0));
    // Five pushes into a depth-4 stack, then drain past empty.
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         1,0, 32'h2000_000A,32'h2000_000A,1,1,32'h2000_000A,0));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         1,0, 32'h2000_000E,32'h2000_000E,1,1,32'h2000_000E,0));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         1,0, 32'h2000_0012,32'h2000_0012,1,1,32'h2000_0012,0));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         1,0, 32'h2000_0016,32'h2000_0016,1,1,32'h2000_0016,0));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         1,0, 32'h2000_001A,32'h2000_001A,1,1,32'h2000_001A,0));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         0,1, 32'h2000_001E,32'h2000_001E,1,1,32'h2000_0016,0));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         0,1, 32'h2000_0022,32'h2000_0022,1,1,32'h2000_0012,0));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         0,1, 32'h2000_0026,32'h2000_0026,1,1,32'h2000_000E,0));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         0,1, 32'h2000_002A,32'h2000_002A,0,0,32'h0,        0));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         0,1, 32'h2000_002E,32'h2000_002E,0,0,32'h0,        0));
    // Push+pop replacement, then stalled push/pop must be ignored.
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         1,0, 32'h2000_0032,32'h2000_0032,1,1,32'h2000_0032,0));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         1,0, 32'h2000_0036,32'h2000_0036,1,1,32'h2000_0036,0));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         1,1, 32'h2000_003A,32'h2000_003A,1,1,32'h2000_003A,0));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         0,1, 32'h2000_003E,32'h2000_003E,1,1,32'h2000_0032,0));
    tbl.push_back(mk(0,1,0,0,32'h0,        0,32'h0,         1,0, 32'h2000_0042,32'h2000_003E,1,1,32'h2000_0032,0));
    tbl.push_back(mk(0,1,0,0,32'h0,        0,32'h0,         0,1, 32'h2000_0042,32'h2000_003E,1,1,32'h2000_0032,0));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         0,1, 32'h2000_0042,32'h2000_0042,0,0,32'h0,        0));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         1,1, 32'h2000_0046,32'h2000_0046,1,1,32'h2000_0046,0));
    tbl.push_back(mk(0,0,0,1,32'h0000_0201,0,32'h0,         1,0, 32'h2000_004A,32'h0000_0200,1,1,32'h2000_004A,1));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,32'h0,         1,0, 32'h0000_0204,32'h0000_0204,1,1,32'h0000_0204,0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Reset mid-stream with three RAS entries, a pending misaligned redirect and a push.
    apply(mk(1,1,0,0,32'h0, 1,32'h3000_0001, 1,0, 32'h0000_0208, RV, 0,0,32'h0, 0), 200);
    apply(mk(0,0,0,0,32'h0, 0,32'h0,         0,0, 32'h1000_0004, 32'h1000_0004, 0,0,32'h0, 0), 201);
    // Misaligned pulse is dropped by a following stall.
    apply(mk(0,0,0,0,32'h0, 1,32'h1000_0101, 0,0, 32'h1000_0008, 32'h1000_0100, 0,0,32'h0, 1), 202);
    apply(mk(0,1,0,0,32'h0, 0,32'h0,         0,0, 32'h1000_0104, 32'h1000_0100, 0,0,32'h0, 0), 203);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
